// File: rtl/cpu_types_pkg.sv
// Shared CPU types for the 5-stage MIPS datapath.
// Register field and hazard sequencer state encodings.
package cpu_types_pkg;

    typedef logic [4:0] regbits_t;

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        HALTED
    } hzd_state_t;

endpackage

// File: rtl/hazard_controller_if.sv
// Bundle of the hazard controller's non-clock, non-reset signals.
// hc is the block side, tb the bench side.
interface hazard_controller_if;
    import cpu_types_pkg::*;

    logic     ihit;
    logic     dhit;
    logic     exmem_dREN;
    logic     exmem_dWEN;
    logic     exmem_pcsrc;
    logic     exmem_halt;
    logic     idex_MemRead;
    regbits_t idex_rt;
    regbits_t ifid_rs;
    regbits_t ifid_rt;
    logic     pc_en;
    logic     ifid_en;
    logic     idex_en;
    logic     exmem_en;
    logic     memwb_en;
    logic     ifid_flush;
    logic     idex_flush;
    logic     exmem_flush;
    logic     halt;

    modport hc (
        input  ihit, dhit, exmem_dREN, exmem_dWEN,
        input  exmem_pcsrc, exmem_halt,
        input  idex_MemRead, idex_rt, ifid_rs, ifid_rt,
        output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
        output ifid_flush, idex_flush, exmem_flush, halt
    );

    modport tb (
        output ihit, dhit, exmem_dREN, exmem_dWEN,
        output exmem_pcsrc, exmem_halt,
        output idex_MemRead, idex_rt, ifid_rs, ifid_rt,
        input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
        input  ifid_flush, idex_flush, exmem_flush, halt
    );

endinterface

// File: rtl/hazard_controller_sat_counter.sv
// Saturating up-counter with enable; sticks at all-ones.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/hazard_controller.sv
// Pipeline sequencer: latch enables/flushes, load-use bubbles,
// memory-wait freezes, branch flushes and HALT drain.
module hazard_controller
    import cpu_types_pkg::*;
#(
    parameter int DRAIN_CYCLES = 2,
    parameter int CNT_W        = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             exmem_dREN,
    input  logic             exmem_dWEN,
    input  logic             exmem_pcsrc,
    input  logic             exmem_halt,
    input  logic             idex_MemRead,
    input  regbits_t         idex_rt,
    input  regbits_t         ifid_rs,
    input  regbits_t         ifid_rt,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic             halt,
    output logic [CNT_W-1:0] stall_count
);

    localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    hzd_state_t    state;
    hzd_state_t    state_nxt;
    logic [DW-1:0] drain_cnt;
    logic [DW-1:0] drain_nxt;
    logic          dmem_wait;
    logic          load_use;

    assign dmem_wait = (exmem_dREN | exmem_dWEN) & ~dhit;

    assign load_use = idex_MemRead
                    & (idex_rt != '0)
                    & ((idex_rt == ifid_rs) | (idex_rt == ifid_rt));

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= RUN;
            drain_cnt <= '0;
        end else begin
            state     <= state_nxt;
            drain_cnt <= drain_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        drain_nxt   = drain_cnt;
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        idex_en     = 1'b0;
        exmem_en    = 1'b0;
        memwb_en    = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        if (!RST) begin
            case (state)
                RUN: begin
                    if (dmem_wait) begin
                        pc_en = 1'b0;
                    end else if (exmem_halt) begin
                        exmem_en    = 1'b1;
                        memwb_en    = 1'b1;
                        exmem_flush = 1'b1;
                        state_nxt   = DRAIN;
                        drain_nxt   = DW'(DRAIN_CYCLES - 1);
                    end else if (exmem_pcsrc) begin
                        pc_en      = 1'b1;
                        ifid_en    = 1'b1;
                        idex_en    = 1'b1;
                        exmem_en   = 1'b1;
                        memwb_en   = 1'b1;
                        ifid_flush = 1'b1;
                        idex_flush = 1'b1;
                    end else if (load_use) begin
                        idex_en    = 1'b1;
                        exmem_en   = 1'b1;
                        memwb_en   = 1'b1;
                        idex_flush = 1'b1;
                    end else if (!ihit) begin
                        ifid_en    = 1'b1;
                        idex_en    = 1'b1;
                        exmem_en   = 1'b1;
                        memwb_en   = 1'b1;
                        ifid_flush = 1'b1;
                    end else begin
                        pc_en    = 1'b1;
                        ifid_en  = 1'b1;
                        idex_en  = 1'b1;
                        exmem_en = 1'b1;
                        memwb_en = 1'b1;
                    end
                end
                DRAIN: begin
                    memwb_en = 1'b1;
                    if (drain_cnt == '0) begin
                        state_nxt = HALTED;
                    end else begin
                        drain_nxt = drain_cnt - DW'(1);
                    end
                end
                default: begin
                    state_nxt = HALTED;
                end
            endcase
        end
    end

    assign halt = (state == HALTED);

    sat_counter #(
        .W(CNT_W)
    ) u_stall_cnt (
        .clk  (CLK),
        .rst  (RST),
        .en   (~pc_en & (state != HALTED)),
        .count(stall_count)
    );

endmodule

// File: tb/tb_hazard_controller.sv
// Directed-vector bench for hazard_controller.
module tb_hazard_controller;
    import cpu_types_pkg::*;

    localparam logic [7:0] C_NORM  = 8'b11111_000;
    localparam logic [7:0] C_LU    = 8'b00111_010;
    localparam logic [7:0] C_FRZ   = 8'b00000_000;
    localparam logic [7:0] C_BR    = 8'b11111_110;
    localparam logic [7:0] C_NOI   = 8'b01111_100;
    localparam logic [7:0] C_HLT   = 8'b00011_001;
    localparam logic [7:0] C_DRN   = 8'b00001_000;

    logic CLK = 1'b0;
    logic RST = 1'b1;

    hazard_controller_if hif ();

    logic [31:0] stall_count;
    logic [3:0]  sat_count;
    logic        s_pc_en, s_ifid_en, s_idex_en;
    logic        s_exmem_en, s_memwb_en;
    logic        s_ifid_fl, s_idex_fl, s_exmem_fl, s_halt;

    int n_run  = 0;
    int n_fail = 0;

    always #5 CLK = ~CLK;

    hazard_controller #(.DRAIN_CYCLES(2), .CNT_W(32)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .ihit        (hif.ihit),
        .dhit        (hif.dhit),
        .exmem_dREN  (hif.exmem_dREN),
        .exmem_dWEN  (hif.exmem_dWEN),
        .exmem_pcsrc (hif.exmem_pcsrc),
        .exmem_halt  (hif.exmem_halt),
        .idex_MemRead(hif.idex_MemRead),
        .idex_rt     (hif.idex_rt),
        .ifid_rs     (hif.ifid_rs),
        .ifid_rt     (hif.ifid_rt),
        .pc_en       (hif.pc_en),
        .ifid_en     (hif.ifid_en),
        .idex_en     (hif.idex_en),
        .exmem_en    (hif.exmem_en),
        .memwb_en    (hif.memwb_en),
        .ifid_flush  (hif.ifid_flush),
        .idex_flush  (hif.idex_flush),
        .exmem_flush (hif.exmem_flush),
        .halt        (hif.halt),
        .stall_count (stall_count)
    );

    hazard_controller #(.DRAIN_CYCLES(2), .CNT_W(4)) dut_sat (
        .CLK         (CLK),
        .RST         (RST),
        .ihit        (hif.ihit),
        .dhit        (hif.dhit),
        .exmem_dREN  (hif.exmem_dREN),
        .exmem_dWEN  (hif.exmem_dWEN),
        .exmem_pcsrc (hif.exmem_pcsrc),
        .exmem_halt  (hif.exmem_halt),
        .idex_MemRead(hif.idex_MemRead),
        .idex_rt     (hif.idex_rt),
        .ifid_rs     (hif.ifid_rs),
        .ifid_rt     (hif.ifid_rt),
        .pc_en       (s_pc_en),
        .ifid_en     (s_ifid_en),
        .idex_en     (s_idex_en),
        .exmem_en    (s_exmem_en),
        .memwb_en    (s_memwb_en),
        .ifid_flush  (s_ifid_fl),
        .idex_flush  (s_idex_fl),
        .exmem_flush (s_exmem_fl),
        .halt        (s_halt),
        .stall_count (sat_count)
    );

    function automatic logic [7:0] ctl();
        return {hif.pc_en, hif.ifid_en, hif.idex_en,
                hif.exmem_en, hif.memwb_en,
                hif.ifid_flush, hif.idex_flush,
                hif.exmem_flush};
    endfunction

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic idle();
        hif.ihit         = 1'b1;
        hif.dhit         = 1'b0;
        hif.exmem_dREN   = 1'b0;
        hif.exmem_dWEN   = 1'b0;
        hif.exmem_pcsrc  = 1'b0;
        hif.exmem_halt   = 1'b0;
        hif.idex_MemRead = 1'b0;
        hif.idex_rt      = '0;
        hif.ifid_rs      = '0;
        hif.ifid_rt      = '0;
    endtask

    task automatic cyc(input string tag, input logic [7:0] exp);
        #1;
        check(tag, {24'd0, ctl()}, {24'd0, exp});
        @(posedge CLK);
        #1;
    endtask

    initial begin
        idle();
        repeat (2) @(posedge CLK);
        #1;
        check("rst_ctl", {24'd0, ctl()}, 32'd0);
        check("rst_halt", {31'd0, hif.halt}, 32'd0);
        check("rst_cnt", stall_count, 32'd0);
        RST = 1'b0;
        cyc("run_norm", C_NORM);
        check("cnt_norm", stall_count, 32'd0);

        hif.idex_MemRead = 1'b1;
        hif.idex_rt      = 5'd8;
        hif.ifid_rs      = 5'd8;
        cyc("lu_rs", C_LU);
        hif.idex_MemRead = 1'b0;
        cyc("lu_after", C_NORM);
        check("cnt_lu", stall_count, 32'd1);

        hif.idex_MemRead = 1'b1;
        hif.ifid_rs      = 5'd3;
        hif.ifid_rt      = 5'd8;
        cyc("lu_rt", C_LU);
        hif.idex_rt      = 5'd0;
        hif.ifid_rs      = 5'd0;
        hif.ifid_rt      = 5'd0;
        cyc("lu_r0", C_NORM);
        idle();
        hif.ihit = 1'b0;
        cyc("no_ihit", C_NOI);
        check("cnt_ihit", stall_count, 32'd3);

        idle();
        hif.exmem_dREN  = 1'b1;
        hif.exmem_pcsrc = 1'b1;
        for (int i = 0; i < 3; i++) cyc("dwait", C_FRZ);
        check("cnt_dwait", stall_count, 32'd6);
        hif.dhit = 1'b1;
        cyc("dhit_br", C_BR);
        check("cnt_dhit", stall_count, 32'd6);

        idle();
        hif.exmem_pcsrc  = 1'b1;
        hif.idex_MemRead = 1'b1;
        hif.idex_rt      = 5'd8;
        hif.ifid_rs      = 5'd8;
        hif.ihit         = 1'b0;
        cyc("br_lu", C_BR);
        hif.exmem_pcsrc = 1'b0;
        hif.exmem_dWEN  = 1'b1;
        cyc("dwen_lu", C_FRZ);
        check("cnt_dwen", stall_count, 32'd7);

        idle();
        RST = 1'b1;
        #1;
        check("mid_rst_ctl", {24'd0, ctl()}, 32'd0);
        check("mid_rst_cnt", stall_count, 32'd0);
        @(posedge CLK);
        #1;
        RST = 1'b0;
        cyc("post_rst", C_NORM);

        hif.exmem_halt = 1'b1;
        hif.exmem_dREN = 1'b1;
        cyc("halt_dwait", C_FRZ);
        hif.exmem_dREN = 1'b0;
        cyc("halt_ex", C_HLT);
        hif.exmem_halt  = 1'b0;
        hif.ihit        = 1'b0;
        hif.exmem_pcsrc = 1'b1;
        cyc("drain1", C_DRN);
        check("halt_d1", {31'd0, hif.halt}, 32'd0);
        cyc("drain2", C_DRN);
        check("halted", {31'd0, hif.halt}, 32'd1);
        check("cnt_halt", stall_count, 32'd4);
        for (int i = 0; i < 3; i++) begin
            hif.ihit        = i[0];
            hif.exmem_pcsrc = ~i[0];
            cyc("halted_ctl", C_FRZ);
        end
        check("halt_sticky", {31'd0, hif.halt}, 32'd1);
        check("cnt_frozen", stall_count, 32'd4);

        idle();
        RST = 1'b1;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        check("unhalt", {31'd0, hif.halt}, 32'd0);
        cyc("unhalt_run", C_NORM);

        hif.ihit = 1'b0;
        for (int i = 0; i < 10; i++) cyc("sat_ihit", C_NOI);
        check("cnt_10", stall_count, 32'd10);
        check("sat_10", {28'd0, sat_count}, 32'd10);
        for (int i = 0; i < 10; i++) cyc("sat_ihit", C_NOI);
        check("cnt_20", stall_count, 32'd20);
        check("sat_hold", {28'd0, sat_count}, 32'd15);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
